// File: rtl/axis_agent_pkg.sv
// Shared AXI-Stream agent types: default bus widths, beat layout and arbiter
// state encoding, plus the round-robin index helper used by the arbiter slice.
package axis_agent_pkg;

  localparam int AXIS_DATA_W = 16;
  localparam int AXIS_ID_W   = 8;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_USER_W = 2;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

  typedef struct packed {
    int unsigned data_w;
    int unsigned id_w;
    int unsigned dest_w;
    int unsigned user_w;
  } bus_widths_t;

  localparam bus_widths_t DEFAULT_BUS_WIDTHS = '{
    data_w: AXIS_DATA_W,
    id_w:   AXIS_ID_W,
    dest_w: AXIS_DEST_W,
    user_w: AXIS_USER_W
  };

  // One beat at the default widths; blocks overriding the widths declare a
  // local struct with the same field order.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0] data;
    logic [AXIS_KEEP_W-1:0] keep;
    logic [AXIS_KEEP_W-1:0] strb;
    logic                   last;
    logic [AXIS_ID_W-1:0]   id;
    logic [AXIS_DEST_W-1:0] dest;
    logic [AXIS_USER_W-1:0] user;
  } axis_beat_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr, wrapping modulo
// NUM_S. Purely combinational so it can sit in front of any grant register.
module axis_rr_pick
  import axis_agent_pkg::*;
#(
  parameter  int NUM_S = 4,
  localparam int PTR_W = $clog2(NUM_S)
) (
  input  logic [NUM_S-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             found
);

  logic [31:0] cand;

  // NOTE: every output and temporary gets a default before the search loop,
  // so no path through this block leaves a value held and no latch appears.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = 32'(ptr);
    for (int i = 0; i < NUM_S; i++) begin
      if (!found && req[cand[PTR_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[PTR_W-1:0];
      end
      cand = rr_next(cand, NUM_S);
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_S AXI-Stream slaves onto one master,
// grant held until the granted source's TLAST beat is accepted.
module axis_rr_arbiter
  import axis_agent_pkg::*;
#(
  parameter  int NUM_S  = 4,
  parameter  int DATA_W = AXIS_DATA_W,
  parameter  int ID_W   = AXIS_ID_W,
  parameter  int DEST_W = AXIS_DEST_W,
  parameter  int USER_W = AXIS_USER_W,
  localparam int KEEP_W = DATA_W / 8,
  localparam int PTR_W  = $clog2(NUM_S)
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_S-1:0]              s_tvalid,
  output logic [NUM_S-1:0]              s_tready,
  input  logic [NUM_S-1:0][DATA_W-1:0]  s_tdata,
  input  logic [NUM_S-1:0][KEEP_W-1:0]  s_tkeep,
  input  logic [NUM_S-1:0][KEEP_W-1:0]  s_tstrb,
  input  logic [NUM_S-1:0]              s_tlast,
  input  logic [NUM_S-1:0][ID_W-1:0]    s_tid,
  input  logic [NUM_S-1:0][DEST_W-1:0]  s_tdest,
  input  logic [NUM_S-1:0][USER_W-1:0]  s_tuser,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [DATA_W-1:0]             m_tdata,
  output logic [KEEP_W-1:0]             m_tkeep,
  output logic [KEEP_W-1:0]             m_tstrb,
  output logic                          m_tlast,
  output logic [ID_W-1:0]               m_tid,
  output logic [DEST_W-1:0]             m_tdest,
  output logic [USER_W-1:0]             m_tuser,
  output logic [PTR_W-1:0]              grant_idx,
  output logic                          busy
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_BUSY = BUSY;

  // Same field order as axis_beat_t, sized by this instance's parameters.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic [KEEP_W-1:0] strb;
    logic              last;
    logic [ID_W-1:0]   id;
    logic [DEST_W-1:0] dest;
    logic [USER_W-1:0] user;
  } beat_t;

  logic [0:0]       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_found;
  logic             out_free;
  logic             accept;
  beat_t            sel_beat;
  beat_t            m_beat;

  axis_rr_pick #(
    .NUM_S (NUM_S)
  ) u_pick (
    .req   (s_tvalid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // The single output stage can take a beat when empty or draining this cycle.
  assign out_free = !m_tvalid || m_tready;
  assign accept   = (state == ST_BUSY) && s_tvalid[grant_idx] && out_free;
  assign busy     = (state == ST_BUSY);

  always_comb begin
    s_tready = '0;
    if (state == ST_BUSY) begin
      s_tready[grant_idx] = out_free;
    end
  end

  always_comb begin
    sel_beat.data = s_tdata[grant_idx];
    sel_beat.keep = s_tkeep[grant_idx];
    sel_beat.strb = s_tstrb[grant_idx];
    sel_beat.last = s_tlast[grant_idx];
    sel_beat.id   = s_tid[grant_idx];
    sel_beat.dest = s_tdest[grant_idx];
    sel_beat.user = s_tuser[grant_idx];
  end

  // NOTE: registers are updated with non-blocking assignments so every branch
  // below reads the pre-edge values of state, grant_idx and m_tvalid.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      m_tvalid  <= 1'b0;
      // NOTE: the payload register is reset as well so the master bus shows
      // zeros after reset instead of stale data from an aborted packet.
      m_beat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_idx <= pick_idx;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && sel_beat.last) begin
            state  <= ST_IDLE;
            rr_ptr <= PTR_W'(rr_next(32'(grant_idx), NUM_S));
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        m_tvalid <= 1'b1;
        m_beat   <= sel_beat;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tdata = m_beat.data;
  assign m_tkeep = m_beat.keep;
  assign m_tstrb = m_beat.strb;
  assign m_tlast = m_beat.last;
  assign m_tid   = m_beat.id;
  assign m_tdest = m_beat.dest;
  assign m_tuser = m_beat.user;

endmodule
